// File: rtl/game_state_ctrl_if.sv
// ============================================================================
// Module : game_state_ctrl_if
// Brief  : Interface that carries the game-event inputs and the screen/sprite
//          control outputs of game_state_ctrl. The pauseKey signal exists only
//          when GAME_PAUSE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_state_ctrl_if #(
  parameter int NUM_LIVES    = 3,
  parameter int PELLET_CNT_W = 8
);
  localparam int LIVES_W = $clog2(NUM_LIVES + 1);

  logic                    startOfFrame;
  logic                    startKey;
  logic                    pelletEaten;
  logic                    pacmanHit;
`ifdef GAME_PAUSE_EN
  logic                    pauseKey;
`endif
  logic                    pressToStart;
  logic                    gameWon;
  logic                    gameLost;
  logic                    gameActive;
  logic [LIVES_W-1:0]      livesLeft;
  logic [PELLET_CNT_W-1:0] pelletsLeft;
  logic                    levelRestart;

  // master: keypad/collision/VGA side that produces events
  modport master (
`ifdef GAME_PAUSE_EN
    output pauseKey,
`endif
    output startOfFrame, startKey, pelletEaten, pacmanHit,
    input  pressToStart, gameWon, gameLost, gameActive,
    input  livesLeft, pelletsLeft, levelRestart
  );

  // slave: the game-flow controller
  modport slave (
`ifdef GAME_PAUSE_EN
    input  pauseKey,
`endif
    input  startOfFrame, startKey, pelletEaten, pacmanHit,
    output pressToStart, gameWon, gameLost, gameActive,
    output livesLeft, pelletsLeft, levelRestart
  );
endinterface

`default_nettype wire

// File: rtl/game_state_ctrl.sv
// ============================================================================
// Module : game_state_ctrl
// Brief  : Game-flow FSM (START/PLAY/RESPAWN/WON/LOST, plus PAUSE when the
//          GAME_PAUSE_EN macro is defined). Tracks lives and pellets and times
//          message screens / respawn freeze in VGA frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_state_ctrl #(
  parameter int NUM_LIVES       = 3,
  parameter int TOTAL_PELLETS   = 150,
  parameter int PELLET_CNT_W    = 8,
  parameter int MSG_HOLD_FRAMES = 180,
  parameter int RESPAWN_FRAMES  = 60
) (
  input logic              clk,
  input logic              resetN,
  game_state_ctrl_if.slave bus
);

  localparam int LIVES_W    = $clog2(NUM_LIVES + 1);
  localparam int MAX_FRAMES = (MSG_HOLD_FRAMES > RESPAWN_FRAMES) ? MSG_HOLD_FRAMES
                                                                  : RESPAWN_FRAMES;
  localparam int FRAME_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [LIVES_W-1:0]      C_LIVES_INIT   = LIVES_W'(NUM_LIVES);
  localparam logic [LIVES_W-1:0]      C_LIVES_ONE    = LIVES_W'(1);
  localparam logic [PELLET_CNT_W-1:0] C_PELLETS_INIT = PELLET_CNT_W'(TOTAL_PELLETS);
  localparam logic [PELLET_CNT_W-1:0] C_PELLETS_ONE  = PELLET_CNT_W'(1);
  localparam logic [PELLET_CNT_W-1:0] C_PELLETS_ZERO = '0;
  localparam logic [FRAME_W-1:0]      C_RESPAWN_LAST = FRAME_W'(RESPAWN_FRAMES - 1);
  localparam logic [FRAME_W-1:0]      C_MSG_LAST     = FRAME_W'(MSG_HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_PLAY    = 3'd1,
    S_RESPAWN = 3'd2,
    S_WON     = 3'd3,
    S_LOST    = 3'd4
`ifdef GAME_PAUSE_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_key_prev;
  logic [FRAME_W-1:0]      r_frame_cnt;
  logic [FRAME_W-1:0]      w_frame_cnt_next;
  logic [LIVES_W-1:0]      r_lives;
  logic [LIVES_W-1:0]      w_lives_next;
  logic [PELLET_CNT_W-1:0] r_pellets;
  logic [PELLET_CNT_W-1:0] w_pellets_next;
  logic                    r_level_restart;
  logic                    w_level_restart_next;
  logic                    r_press_to_start;
  logic                    r_game_won;
  logic                    r_game_lost;
  logic                    r_game_active;

  logic                    w_start_rise;
  logic                    w_win;
  logic                    w_timed;
  logic                    w_pause_rise;

  assign w_start_rise = bus.startKey & ~r_key_prev;
  assign w_win        = bus.pelletEaten && (r_pellets == C_PELLETS_ONE);
  assign w_timed      = (r_state == S_RESPAWN) || (r_state == S_WON) || (r_state == S_LOST);

`ifdef GAME_PAUSE_EN
  logic r_pause_prev;

  assign w_pause_rise = bus.pauseKey & ~r_pause_prev;

  // Reset to 1 so a pause key held through reset does not toggle pause.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pause_prev <= 1'b1;
    end else begin
      r_pause_prev <= bus.pauseKey;
    end
  end
`else
  assign w_pause_rise = 1'b0;
`endif

  always_comb begin
    w_state_next         = r_state;
    w_lives_next         = r_lives;
    w_pellets_next       = r_pellets;
    w_level_restart_next = 1'b0;

    case (r_state)
      S_START: begin
        if (w_start_rise) begin
          w_state_next         = S_PLAY;
          w_lives_next         = C_LIVES_INIT;
          w_pellets_next       = C_PELLETS_INIT;
          w_level_restart_next = 1'b1;
        end
      end

      S_PLAY: begin
        if (bus.pelletEaten && (r_pellets != C_PELLETS_ZERO)) begin
          w_pellets_next = r_pellets - 1'b1;
        end
        // Eating the last pellet wins even if a ghost hits on the same cycle.
        if (w_win) begin
          w_state_next = S_WON;
        end else if (bus.pacmanHit) begin
          if (r_lives <= C_LIVES_ONE) begin
            w_state_next = S_LOST;
            w_lives_next = '0;
          end else begin
            w_state_next = S_RESPAWN;
            w_lives_next = r_lives - 1'b1;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (w_pause_rise) begin
          w_state_next = S_PAUSE;
        end
`endif
      end

      S_RESPAWN: begin
        if (bus.startOfFrame && (r_frame_cnt == C_RESPAWN_LAST)) begin
          w_state_next         = S_PLAY;
          w_level_restart_next = 1'b1;
        end
      end

      S_WON, S_LOST: begin
        if (bus.startOfFrame && (r_frame_cnt == C_MSG_LAST)) begin
          w_state_next = S_START;
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (w_pause_rise) begin
          w_state_next = S_PLAY;
        end
      end
`endif

      default: begin
        w_state_next = S_START;
      end
    endcase
  end

  // Frames are only counted in timed screens, so the counter cannot wrap.
  always_comb begin
    w_frame_cnt_next = r_frame_cnt;
    if (w_state_next != r_state) begin
      w_frame_cnt_next = '0;
    end else if (w_timed && bus.startOfFrame) begin
      w_frame_cnt_next = r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= S_START;
      r_key_prev       <= 1'b1;
      r_frame_cnt      <= '0;
      r_lives          <= C_LIVES_INIT;
      r_pellets        <= C_PELLETS_INIT;
      r_level_restart  <= 1'b0;
      r_press_to_start <= 1'b1;
      r_game_won       <= 1'b0;
      r_game_lost      <= 1'b0;
      r_game_active    <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_key_prev       <= bus.startKey;
      r_frame_cnt      <= w_frame_cnt_next;
      r_lives          <= w_lives_next;
      r_pellets        <= w_pellets_next;
      r_level_restart  <= w_level_restart_next;
      r_press_to_start <= (w_state_next == S_START);
      r_game_won       <= (w_state_next == S_WON);
      r_game_lost      <= (w_state_next == S_LOST);
      r_game_active    <= (w_state_next == S_PLAY);
    end
  end

  assign bus.pressToStart = r_press_to_start;
  assign bus.gameWon      = r_game_won;
  assign bus.gameLost     = r_game_lost;
  assign bus.gameActive   = r_game_active;
  assign bus.livesLeft    = r_lives;
  assign bus.pelletsLeft  = r_pellets;
  assign bus.levelRestart = r_level_restart;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// ============================================================================
// Module : tb_game_state_ctrl
// Brief  : Directed, table-driven bench for game_state_ctrl with small
//          parameters; extra pause sequence when GAME_PAUSE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_state_ctrl;

  logic clk;
  logic resetN;
  int   total;
  int   bad;

  game_state_ctrl_if #(.NUM_LIVES(2), .PELLET_CNT_W(8)) bus ();

  game_state_ctrl #(
    .NUM_LIVES      (2),
    .TOTAL_PELLETS  (3),
    .PELLET_CNT_W   (8),
    .MSG_HOLD_FRAMES(4),
    .RESPAWN_FRAMES (2)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs then expected outputs for one clock cycle.
  typedef struct packed {
    logic       sk;
    logic       sof;
    logic       pe;
    logic       hit;
    logic       pts;
    logic       won;
    logic       lost;
    logic       act;
    logic [1:0] lives;
    logic [7:0] pel;
    logic       rst;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sk, input logic sof, input logic pe, input logic hit,
                     input logic pts, input logic won, input logic lost, input logic act,
                     input logic [1:0] lives, input logic [7:0] pel, input logic rst);
    vec_t v;
    v.sk = sk; v.sof = sof; v.pe = pe; v.hit = hit;
    v.pts = pts; v.won = won; v.lost = lost; v.act = act;
    v.lives = lives; v.pel = pel; v.rst = rst;
    vq.push_back(v);
  endtask

  function automatic logic [14:0] obs();
    return {bus.pressToStart, bus.gameWon, bus.gameLost, bus.gameActive,
            bus.livesLeft, bus.pelletsLeft, bus.levelRestart};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic sk, input logic sof, input logic pe, input logic hit);
    bus.startKey     = sk;
    bus.startOfFrame = sof;
    bus.pelletEaten  = pe;
    bus.pacmanHit    = hit;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetN = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef GAME_PAUSE_EN
    bus.pauseKey = 1'b0;
`endif

    //   sk sof pe hit | pts won lost act lives pel rst
    add(1, 0, 0, 0,   1, 0, 0, 0, 2, 3, 0);  // key held through reset: no start
    add(0, 0, 0, 0,   1, 0, 0, 0, 2, 3, 0);
    add(1, 0, 0, 0,   0, 0, 0, 1, 2, 3, 1);  // rising edge starts game
    add(1, 0, 0, 0,   0, 0, 0, 1, 2, 3, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 2, 2, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 1, 0,   0, 1, 0, 0, 2, 0, 0);  // last pellet -> WON
    add(0, 0, 1, 1,   0, 1, 0, 0, 2, 0, 0);  // ignored in WON
    add(0, 1, 0, 0,   0, 1, 0, 0, 2, 0, 0);
    add(1, 1, 0, 0,   0, 1, 0, 0, 2, 0, 0);  // start edge ignored in WON
    add(0, 1, 0, 0,   0, 1, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0,   0, 1, 0, 0, 2, 0, 0);
    add(0, 1, 0, 0,   1, 0, 0, 0, 2, 0, 0);  // 4th frame -> START
    add(0, 0, 1, 1,   1, 0, 0, 0, 2, 0, 0);  // ignored in START
    add(1, 0, 0, 0,   0, 0, 0, 1, 2, 3, 1);  // reload counters
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 3, 0);  // hit -> RESPAWN
    add(0, 0, 1, 1,   0, 0, 0, 0, 1, 3, 0);  // ignored in RESPAWN
    add(0, 1, 0, 0,   0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0,   0, 0, 0, 1, 1, 3, 1);  // 2nd frame -> PLAY
    add(0, 0, 1, 0,   0, 0, 0, 1, 1, 2, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1,   0, 1, 0, 0, 1, 0, 0);  // win beats simultaneous hit
    add(0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0,   0, 0, 0, 1, 2, 3, 1);
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0,   0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0,   0, 0, 0, 1, 1, 3, 1);
    add(0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);  // last life -> LOST
    add(0, 0, 1, 1,   0, 0, 1, 0, 0, 3, 0);  // ignored in LOST
    add(0, 1, 0, 0,   0, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 0,   0, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 0,   0, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 0,   1, 0, 0, 0, 0, 3, 0);

    repeat (3) cycle();
    chk("reset_pressToStart", 32'(bus.pressToStart), 32'd1);
    chk("reset_flags", {29'd0, bus.gameWon, bus.gameLost, bus.gameActive}, 32'd0);
    chk("reset_lives", 32'(bus.livesLeft), 32'd2);
    chk("reset_pellets", 32'(bus.pelletsLeft), 32'd3);
    chk("reset_levelRestart", 32'(bus.levelRestart), 32'd0);

    @(negedge clk);
    resetN = 1'b1;
    #4;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sk, vq[i].sof, vq[i].pe, vq[i].hit);
      cycle();
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({vq[i].pts, vq[i].won, vq[i].lost, vq[i].act,
               vq[i].lives, vq[i].pel, vq[i].rst}));
    end

    // Mid-game asynchronous reset with the start key held.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("mid_start_active", 32'(bus.gameActive), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("mid_pellet", 32'(bus.pelletsLeft), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(obs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd3, 1'b0}));
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("held_key_no_start%0d", i), 32'({bus.pressToStart, bus.levelRestart}), 32'd2);
    end

`ifdef GAME_PAUSE_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("pause_pre_active", 32'(bus.gameActive), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bus.pauseKey = 1'b1;
    cycle();
    chk("pause_flags", {28'd0, bus.pressToStart, bus.gameWon, bus.gameLost, bus.gameActive}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("pause_frozen", 32'({bus.livesLeft, bus.pelletsLeft}), 32'({2'd2, 8'd3}));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bus.pauseKey = 1'b0;
    cycle();
    bus.pauseKey = 1'b1;
    cycle();
    chk("resume_active_norestart", 32'({bus.gameActive, bus.levelRestart}), 32'd2);
    bus.pauseKey = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
